branch_issue_queue: RTL and testbench
=====================================

// Module: branch_issue_queue
// PURPOSE
//  Reservation station and issue scheduler in front of BranchUnit (JZ/JNZ/JS/JNS).
//  Holds dispatched branch ops until both operands (vt = target, va = condition) are resolved.
//  Snoops the CDB for operand values and issues at most one op per cycle, oldest-ready first.
//  issue_* outputs connect directly to BranchUnit opcode/in_index/in_valid/vt/va.
// PARAMETERS
//  DEPTH   4   number of entries (>=2)
//  WIDTH   16  operand data width
// PORTS
//  clk                 in   1             clock
//  reset               in   1             synchronous, active-high
//  dispatch_valid      in   1             dispatch request
//  dispatch_opcode     in   4             branch opcode
//  dispatch_rob_index  in   4             ROB index of the branch
//  dispatch_vt_ready   in   1             1: dispatch_vt is a value; 0: dispatch_vt[3:0] is a producer ROB tag
//  dispatch_vt         in   WIDTH         target value or tag
//  dispatch_va_ready   in   1             same as vt_ready, for va
//  dispatch_va         in   WIDTH         condition value or tag
//  full                out  1             count == DEPTH; dispatch ignored
//  count               out  $clog2(DEPTH)+1  occupied entries
//  cdb_valid           in   1             CDB broadcast
//  cdb_rob_index       in   4             producer tag
//  cdb_value           in   WIDTH         produced value
//  flush               in   1             squash all entries (mispredict recovery)
//  issue_valid         out  1             -> BranchUnit in_valid
//  issue_opcode        out  4             -> opcode
//  issue_rob_index     out  4             -> in_index
//  issue_vt            out  WIDTH         -> vt
//  issue_va            out  WIDTH         -> va
// BEHAVIOUR
//  - Reset: all entries invalid; count=0; full=0; issue_valid=0; issue_opcode/rob_index/vt/va = 0.
//  - Storage: collapsing queue. Slot 0 holds the oldest entry; valid slots are contiguous from 0.
//  - Entry fields: opcode, rob_index, vt, vt_rdy, va, va_rdy.
//  - Wakeup: if cdb_valid, every valid entry with !x_rdy && x[3:0]==cdb_rob_index loads cdb_value
//    and sets x_rdy. An entry woken in cycle N is first eligible for selection in cycle N+1.
//  - Dispatch snoop: a dispatched operand that is not ready also compares against the CDB in the
//    same cycle and is stored ready on a match.
//  - Select: in cycle N, pick the lowest slot with vt_rdy && va_rdy, evaluated on registered state.
//    At the edge ending N, load issue_* from that slot, set issue_valid=1, remove the slot, and
//    shift the higher slots down by one. With no ready slot, issue_valid=0 and the issue data
//    registers hold their values.
//  - Dispatch accept: accepted iff dispatch_valid && !full, with full taken from cycle-start count.
//    A slot freed by the same-cycle issue does not allow a dispatch while full.
//    The new entry is written at index (count - issued), i.e. after compaction.
//  - Latency: dispatch with both operands ready in cycle N -> issue_valid high in cycle N+2
//    (empty queue, macro off).
//  - count_next = count + accepted - issued; never exceeds DEPTH and never underflows.
//  - flush: priority over dispatch, wakeup and select. Next cycle: all entries invalid, count=0,
//    issue_valid=0. Same-cycle dispatch is dropped.
//  - Reset mid-operation behaves as flush and also zeroes the issue data registers.
//  - No back-pressure: BranchUnit accepts one op every cycle.
// CONFIGURATION
//  BRANCH_ISSUE_BYPASS_EN defined:
//    - Accepted dispatch with both operands ready (including via same-cycle CDB snoop), and no
//      stored entry selected that cycle, loads issue_* directly at the edge ending N.
//    - issue_valid is high in N+1 and the entry is not stored; count is unchanged.
//  Undefined: every dispatch goes through storage; minimum latency is 2 cycles.
// TESTING
//  1 reset -> count=0, full=0, issue_valid=0, issue_* = 0 on the cycle after reset deasserts.
//  2 dispatch JZ (op=8, rob=3, vt=0x0040 rdy, va=0 rdy) into empty queue -> issue_valid=1,
//    op=8, rob=3, vt=0x0040 two cycles later (one with BRANCH_ISSUE_BYPASS_EN); count back to 0.
//  3 dispatch A(rob=1, va tag 5) then B(rob=2, ready) -> B issues first; cdb_valid, tag 5,
//    value 0x0007 -> A issues the cycle after wakeup with va=0x0007.
//  4 fill DEPTH=4 entries, none ready -> full=1; 5th dispatch ignored (count stays 4);
//    wake slot 2 -> only it issues, order of slots 0/1/3 preserved.
//  5 dispatch with va tag 6 while cdb_valid carries tag 6, value 0x1234 -> entry stored ready,
//    issues with va=0x1234.
//  6 3 entries held, then flush together with dispatch_valid -> next cycle count=0,
//    issue_valid=0, no later issue from the dropped dispatch.

Source files
------------

// File: rtl/branch_issue_queue.sv
// branch_issue_queue
// Reservation station and issue scheduler in front of the branch unit.
// Holds dispatched branch ops in a collapsing queue (slot 0 = oldest).
// Each op waits until both its target (vt) and condition (va) operands are
// resolved. Operands are captured by snooping the CDB. At most one op issues
// per cycle, and the oldest ready op is chosen.
//
// Optional feature: define BRANCH_ISSUE_BYPASS_EN to let a fully ready
// dispatch go straight to the issue registers. This bypass is used only when
// no stored entry is selected that cycle, and the bypassed op never occupies
// a slot.

module branch_issue_queue #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     dispatch_valid,
  input  logic [3:0]               dispatch_opcode,
  input  logic [3:0]               dispatch_rob_index,
  input  logic                     dispatch_vt_ready,
  input  logic [WIDTH-1:0]         dispatch_vt,
  input  logic                     dispatch_va_ready,
  input  logic [WIDTH-1:0]         dispatch_va,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     cdb_valid,
  input  logic [3:0]               cdb_rob_index,
  input  logic [WIDTH-1:0]         cdb_value,
  input  logic                     flush,
  output logic                     issue_valid,
  output logic [3:0]               issue_opcode,
  output logic [3:0]               issue_rob_index,
  output logic [WIDTH-1:0]         issue_vt,
  output logic [WIDTH-1:0]         issue_va
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [3:0]       opcode;
    logic [3:0]       rob_index;
    logic [WIDTH-1:0] vt;
    logic             vt_rdy;
    logic [WIDTH-1:0] va;
    logic             va_rdy;
  } entry_t;

  entry_t q      [DEPTH];
  entry_t woken  [DEPTH];
  entry_t q_nxt  [DEPTH];
  entry_t disp_e;

  logic [DEPTH-1:0] slot_valid;
  logic [DEPTH-1:0] slot_ready;
  logic             sel_found;
  logic [IW-1:0]    sel_idx;
  logic             accept;
  logic             bypass;
  logic             store;
  logic [CW-1:0]    wr_idx;
  logic [CW-1:0]    count_nxt;
  logic             disp_vt_hit;
  logic             disp_va_hit;

  assign full = (count == CW'(DEPTH));

  // Occupancy and readiness of every slot, taken from registered state only.
  // This is why a wakeup becomes visible to select one cycle later.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      slot_valid[i] = (CW'(i) < count);
      slot_ready[i] = slot_valid[i] && q[i].vt_rdy && q[i].va_rdy;
    end
  end

  // Oldest-ready select: scan from the top down, so the lowest ready slot is the last one written.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (slot_ready[i]) begin
        sel_found = 1'b1;
        sel_idx   = IW'(i);
      end
    end
  end

  // CDB wakeup: a waiting operand whose tag matches the broadcast captures the broadcast value.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i] = q[i];
      if (cdb_valid && slot_valid[i]) begin
        if (!q[i].vt_rdy && (q[i].vt[3:0] == cdb_rob_index)) begin
          woken[i].vt     = cdb_value;
          woken[i].vt_rdy = 1'b1;
        end
        if (!q[i].va_rdy && (q[i].va[3:0] == cdb_rob_index)) begin
          woken[i].va     = cdb_value;
          woken[i].va_rdy = 1'b1;
        end
      end
    end
  end

  // Build the incoming entry. Operands still waiting also snoop the CDB, so a same-cycle broadcast is not missed.
  always_comb begin
    disp_vt_hit      = !dispatch_vt_ready && cdb_valid && (dispatch_vt[3:0] == cdb_rob_index);
    disp_va_hit      = !dispatch_va_ready && cdb_valid && (dispatch_va[3:0] == cdb_rob_index);
    disp_e.opcode    = dispatch_opcode;
    disp_e.rob_index = dispatch_rob_index;
    disp_e.vt        = disp_vt_hit ? cdb_value : dispatch_vt;
    disp_e.vt_rdy    = dispatch_vt_ready || disp_vt_hit;
    disp_e.va        = disp_va_hit ? cdb_value : dispatch_va;
    disp_e.va_rdy    = dispatch_va_ready || disp_va_hit;
  end

  // Full is judged on the cycle-start count, so a slot freed by this cycle's issue cannot be reused in the same cycle.
  assign accept = dispatch_valid && !full;

`ifdef BRANCH_ISSUE_BYPASS_EN
  assign bypass = accept && disp_e.vt_rdy && disp_e.va_rdy && !sel_found;
`else
  assign bypass = 1'b0;
`endif

  assign store     = accept && !bypass;
  assign wr_idx    = count - CW'(sel_found);
  assign count_nxt = count + CW'(store) - CW'(sel_found);

  // Next queue image: compact over the issued slot, then append the new entry just past the survivors.
  always_comb begin
    for (int j = 0; j < DEPTH; j++) begin
      q_nxt[j] = woken[j];
    end
    if (sel_found) begin
      for (int j = 0; j < DEPTH - 1; j++) begin
        if (IW'(j) >= sel_idx) begin
          q_nxt[j] = woken[j + 1];
        end
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (store && (CW'(j) == wr_idx)) begin
        q_nxt[j] = disp_e;
      end
    end
  end

  // State update. Flush only empties the queue and drops the issue strobe;
  // the issue data registers keep their values until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count           <= '0;
      issue_valid     <= 1'b0;
      issue_opcode    <= '0;
      issue_rob_index <= '0;
      issue_vt        <= '0;
      issue_va        <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else if (flush) begin
      count       <= '0;
      issue_valid <= 1'b0;
    end else begin
      count       <= count_nxt;
      issue_valid <= sel_found || bypass;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= q_nxt[i];
      end
      if (sel_found) begin
        issue_opcode    <= q[sel_idx].opcode;
        issue_rob_index <= q[sel_idx].rob_index;
        issue_vt        <= q[sel_idx].vt;
        issue_va        <= q[sel_idx].va;
      end else if (bypass) begin
        issue_opcode    <= disp_e.opcode;
        issue_rob_index <= disp_e.rob_index;
        issue_vt        <= disp_e.vt;
        issue_va        <= disp_e.va;
      end
    end
  end

endmodule

// File: tb/tb_branch_issue_queue.sv
// Directed bench for branch_issue_queue (DEPTH=4, WIDTH=16).
// Expected values are hand-derived. Latency differs when BRANCH_ISSUE_BYPASS_EN is defined.

module tb_branch_issue_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        dispatch_valid;
  logic [3:0]  dispatch_opcode;
  logic [3:0]  dispatch_rob_index;
  logic        dispatch_vt_ready;
  logic [15:0] dispatch_vt;
  logic        dispatch_va_ready;
  logic [15:0] dispatch_va;
  logic        full;
  logic [2:0]  count;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_index;
  logic [15:0] cdb_value;
  logic        flush;
  logic        issue_valid;
  logic [3:0]  issue_opcode;
  logic [3:0]  issue_rob_index;
  logic [15:0] issue_vt;
  logic [15:0] issue_va;

  int vectors = 0;
  int miscompares = 0;

  branch_issue_queue #(.DEPTH(4), .WIDTH(16)) dut (
    .clk(clk), .reset(reset),
    .dispatch_valid(dispatch_valid), .dispatch_opcode(dispatch_opcode),
    .dispatch_rob_index(dispatch_rob_index), .dispatch_vt_ready(dispatch_vt_ready),
    .dispatch_vt(dispatch_vt), .dispatch_va_ready(dispatch_va_ready), .dispatch_va(dispatch_va),
    .full(full), .count(count),
    .cdb_valid(cdb_valid), .cdb_rob_index(cdb_rob_index), .cdb_value(cdb_value),
    .flush(flush),
    .issue_valid(issue_valid), .issue_opcode(issue_opcode), .issue_rob_index(issue_rob_index),
    .issue_vt(issue_vt), .issue_va(issue_va)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    dispatch_valid = 1'b0;
    cdb_valid      = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic [3:0] rob,
                      input logic vtr, input logic [15:0] vt,
                      input logic var_, input logic [15:0] va);
    dispatch_valid     = 1'b1;
    dispatch_opcode    = op;
    dispatch_rob_index = rob;
    dispatch_vt_ready  = vtr;
    dispatch_vt        = vt;
    dispatch_va_ready  = var_;
    dispatch_va        = va;
  endtask

  task automatic cdb(input logic [3:0] tag, input logic [15:0] val);
    cdb_valid     = 1'b1;
    cdb_rob_index = tag;
    cdb_value     = val;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle();
    disp(4'hF, 4'hF, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF);
    tick(); tick();
    reset = 1'b0;
    idle();
    tick();
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL reset_count: got %0d expected 0", count); end
    vectors++; if (full !== 1'b0) begin miscompares++; $display("FAIL reset_full: got %0b expected 0", full); end
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL reset_issue_valid: got %0b expected 0", issue_valid); end
    vectors++; if (issue_opcode !== 4'h0) begin miscompares++; $display("FAIL reset_opcode: got %0h expected 0", issue_opcode); end
    vectors++; if (issue_rob_index !== 4'h0) begin miscompares++; $display("FAIL reset_rob: got %0h expected 0", issue_rob_index); end
    vectors++; if (issue_vt !== 16'h0) begin miscompares++; $display("FAIL reset_vt: got %0h expected 0", issue_vt); end
    vectors++; if (issue_va !== 16'h0) begin miscompares++; $display("FAIL reset_va: got %0h expected 0", issue_va); end
  endtask

  task automatic test_single_issue();
    disp(4'h8, 4'h3, 1'b1, 16'h0040, 1'b1, 16'h0000);
    tick();
    idle();
`ifndef BRANCH_ISSUE_BYPASS_EN
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL single_early: got %0b expected 0", issue_valid); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL single_count_mid: got %0d expected 1", count); end
    tick();
`endif
    vectors++; if (issue_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid: got %0b expected 1", issue_valid); end
    vectors++; if (issue_opcode !== 4'h8) begin miscompares++; $display("FAIL single_op: got %0h expected 8", issue_opcode); end
    vectors++; if (issue_rob_index !== 4'h3) begin miscompares++; $display("FAIL single_rob: got %0h expected 3", issue_rob_index); end
    vectors++; if (issue_vt !== 16'h0040) begin miscompares++; $display("FAIL single_vt: got %0h expected 40", issue_vt); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL single_count: got %0d expected 0", count); end
    tick();
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL single_drop: got %0b expected 0", issue_valid); end
  endtask

  task automatic test_out_of_order();
    disp(4'h9, 4'h1, 1'b1, 16'h0100, 1'b0, 16'h0005);
    tick();
    disp(4'hA, 4'h2, 1'b1, 16'h0200, 1'b1, 16'h0001);
    tick();
    idle();
`ifndef BRANCH_ISSUE_BYPASS_EN
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_early: got %0b expected 0", issue_valid); end
    tick();
`endif
    vectors++; if (issue_valid !== 1'b1 || issue_rob_index !== 4'h2) begin miscompares++; $display("FAIL ooo_b_first: got v=%0b rob=%0h expected v=1 rob=2", issue_valid, issue_rob_index); end
    vectors++; if (count !== 3'd1) begin miscompares++; $display("FAIL ooo_count: got %0d expected 1", count); end
    cdb(4'h5, 16'h0007);
    tick();
    idle();
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL ooo_wake_latency: got %0b expected 0", issue_valid); end
    tick();
    vectors++; if (issue_valid !== 1'b1 || issue_rob_index !== 4'h1) begin miscompares++; $display("FAIL ooo_a: got v=%0b rob=%0h expected v=1 rob=1", issue_valid, issue_rob_index); end
    vectors++; if (issue_va !== 16'h0007 || issue_vt !== 16'h0100) begin miscompares++; $display("FAIL ooo_a_data: got vt=%0h va=%0h expected vt=100 va=7", issue_vt, issue_va); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL ooo_count_end: got %0d expected 0", count); end
  endtask

  task automatic test_full();
    for (int k = 0; k < 4; k++) begin
      disp(4'(k), 4'(8 + k), 1'b1, 16'(16'h0010 + k), 1'b0, 16'(1 + k));
      tick();
    end
    idle();
    vectors++; if (count !== 3'd4 || full !== 1'b1) begin miscompares++; $display("FAIL full_set: got count=%0d full=%0b expected 4/1", count, full); end
    disp(4'hE, 4'hF, 1'b1, 16'h0EEE, 1'b1, 16'h0EEE);
    tick();
    idle();
    vectors++; if (count !== 3'd4) begin miscompares++; $display("FAIL full_drop_count: got %0d expected 4", count); end
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL full_drop_issue: got %0b expected 0", issue_valid); end
    cdb(4'h3, 16'h0333);
    tick();
    idle();
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL full_wake_early: got %0b expected 0", issue_valid); end
    tick();
    vectors++; if (issue_valid !== 1'b1 || issue_rob_index !== 4'hA || issue_va !== 16'h0333) begin miscompares++; $display("FAIL full_slot2: got v=%0b rob=%0h va=%0h expected 1/a/333", issue_valid, issue_rob_index, issue_va); end
    vectors++; if (count !== 3'd3 || full !== 1'b0) begin miscompares++; $display("FAIL full_after: got count=%0d full=%0b expected 3/0", count, full); end
    cdb(4'h4, 16'h0004);
    tick();
    vectors++; if (issue_valid !== 1'b0) begin miscompares++; $display("FAIL order_quiet: got %0b expected 0", issue_valid); end
    cdb(4'h2, 16'h0002);
    tick();
    vectors++; if (issue_valid !== 1'b1 || issue_rob_index !== 4'hB || issue_va !== 16'h0004 || issue_opcode !== 4'h3) begin miscompares++; $display("FAIL order_k3: got v=%0b rob=%0h va=%0h expected 1/b/4", issue_valid, issue_rob_index, issue_va); end
    vectors++; if (count !== 3'd2) begin miscompares++; $display("FAIL order_count2: got %0d expected 2", count); end
    cdb(4'h1, 16'h0001);
    tick();
    idle();
    vectors++; if (issue_valid !== 1'b1 || issue_rob_index !== 4'h9 || issue_va !== 16'h0002 || issue_vt !== 16'h0011) begin miscompares++; $display("FAIL order_k1: got v=%0b rob=%0h va=%0h expected 1/9/2", issue_valid, issue_rob_index, issue_va); end
    tick();
    vectors++; if (issue_valid !== 1'b1 || issue_rob_index !== 4'h8 || issue_va !== 16'h0001 || issue_vt !== 16'h0010) begin miscompares++; $display("FAIL order_k0: got v=%0b rob=%0h va=%0h expected 1/8/1", issue_valid, issue_rob_index, issue_va); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL order_count0: got %0d expected 0", count); end
  endtask

  task automatic test_dispatch_snoop();
    tick();
    disp(4'h5, 4'h7, 1'b1, 16'h0055, 1'b0, 16'h0006);
    cdb(4'h6, 16'h1234);
    tick();
    idle();
`ifndef BRANCH_ISSUE_BYPASS_EN
    vectors++; if (count !== 3'd1 || issue_valid !== 1'b0) begin miscompares++; $display("FAIL snoop_stored: got count=%0d v=%0b expected 1/0", count, issue_valid); end
    tick();
`endif
    vectors++; if (issue_valid !== 1'b1 || issue_rob_index !== 4'h7 || issue_va !== 16'h1234) begin miscompares++; $display("FAIL snoop_issue: got v=%0b rob=%0h va=%0h expected 1/7/1234", issue_valid, issue_rob_index, issue_va); end
    vectors++; if (count !== 3'd0) begin miscompares++; $display("FAIL snoop_count: got %0d expected 0", count); end
  endtask

  task automatic test_flush();
    tick();
    for (int k = 0; k < 3; k++) begin
      disp(4'h1, 4'(1 + k), 1'b1, 16'h0100, 1'b0, 16'(9 + k));
      tick();
    end
    idle();
    vectors++; if (count !== 3'd3) begin miscompares++; $display("FAIL flush_pre: got %0d expected 3", count); end
    flush = 1'b1;
    disp(4'h2, 4'hE, 1'b1, 16'h0ABC, 1'b1, 16'h0DEF);
    tick();
    idle();
    vectors++; if (count !== 3'd0 || issue_valid !== 1'b0) begin miscompares++; $display("FAIL flush_clear: got count=%0d v=%0b expected 0/0", count, issue_valid); end
    for (int k = 0; k < 3; k++) begin
      tick();
      vectors++; if (issue_valid !== 1'b0 || count !== 3'd0) begin miscompares++; $display("FAIL flush_dropped: got v=%0b count=%0d expected 0/0", issue_valid, count); end
    end
  endtask

  initial begin
    test_reset();
    test_single_issue();
    test_out_of_order();
    test_full();
    test_dispatch_snoop();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
